// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state type, PC defaults and the queue entry layout.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fetch_state_t;

    localparam logic [31:0] DEF_PC_STEP  = 32'd4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          DEF_QDEPTH   = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO holding fetched {pc, instr} pairs.
// Ports: clk, reset_n, flush, push, pop, din -> head, count.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t e0;
    fetch_entry_t e1;
    logic         pop_ok;
    logic         push_ok;

    // Guard against pop on empty and push on full without a pop.
    always_comb begin
        pop_ok  = pop && (count != 2'd0);
        push_ok = push && ((count != 2'd2) || pop_ok);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e0    <= '0;
            e1    <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else if (push_ok && pop_ok) begin
            if (count == 2'd2) begin
                e0 <= e1;
                e1 <= din;
            end else begin
                e0 <= din;
            end
        end else if (push_ok) begin
            if (count == 2'd0) begin
                e0 <= din;
            end else begin
                e1 <= din;
            end
            count <= count + 2'd1;
        end else if (pop_ok) begin
            e0    <= e1;
            count <= count - 2'd1;
        end
    end

    assign head = e0;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, reads imem, queues words for decode.
// Ports: clk, reset_n, enable, halt_req, redirect_valid/pc, imem_*, instr_*, halted.
// Optional: FETCH_PERF_CNT_EN adds fetch_count and stall_count outputs.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] PC_STEP  = DEF_PC_STEP,
    parameter int          QDEPTH   = DEF_QDEPTH
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        halt_req,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic        imem_we,
    input  logic [31:0] imem_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    localparam logic [1:0] QFULL = 2'(QDEPTH);

    fetch_state_t state;
    fetch_state_t state_nx;
    logic [31:0]  pc;
    logic         halt_seen;
    logic         halt_eff;
    logic         run;
    logic         redirect;
    logic         push;
    logic         pop;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t din;

    always_comb begin
        run      = (state == RUN);
        halt_eff = halt_seen || halt_req;
        redirect = run && redirect_valid;
        pop      = instr_valid && instr_ready && !redirect;
        push     = run && enable && !halt_eff && !redirect
                   && ((count < QFULL) || pop);
        din      = '{pc: pc, instr: imem_data};
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (enable) state_nx = RUN;
            RUN:     if (halt_eff && (count == 2'd0)) state_nx = HALTED;
            HALTED:  state_nx = HALTED;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            halt_seen <= 1'b0;
        end else begin
            state <= state_nx;
            if (redirect) begin
                pc <= redirect_pc & ~32'h3;
            end else if (push) begin
                pc <= pc + PC_STEP;
            end
            if (run && halt_req) begin
                halt_seen <= 1'b1;
            end
        end
    end

    fetch_queue u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (redirect),
        .push    (push),
        .pop     (pop),
        .din     (din),
        .head    (head),
        .count   (count)
    );

    // Head fields read as zero while the queue is empty.
    always_comb begin
        instr_valid = (count != 2'd0);
        instr_data  = instr_valid ? head.instr : 32'h0;
        instr_pc    = instr_valid ? head.pc : 32'h0;
        imem_addr   = pc;
        imem_we     = 1'b0;
        halted      = (state == HALTED);
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count <= 32'h0;
            stall_count <= 32'h0;
        end else begin
            if (push) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (instr_valid && !instr_ready) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule
